// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: FSM state encoding and default SIZE/NREQ/IDW for the shared-register load arbiter
package reg_arb_pkg;
  localparam int SIZE_D = 32;
  localparam int NREQ_D = 4;
  localparam int IDW_D = 2;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin pick from req starting at p (masked >=p encode, else unmasked); ports req,p in / win one-hot, idx out
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  p,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  idx
);
  logic [NREQ-1:0] mreq;
  assign mreq = req & ~((NREQ'(1) << p) - NREQ'(1));
  always_comb begin
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) idx = req[i] ? IDW'(i) : idx;
    for (int i = NREQ - 1; i >= 0; i--) idx = mreq[i] ? IDW'(i) : idx;
  end
  assign win = |req ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin arbiter loading one shared register, valid/ready consumer side; ports clk,rst,req,req_data,reg_q,out_ready in / grant,reg_load,reg_din,out_valid,out_data,out_id out
module reg_load_arbiter import reg_arb_pkg::*; #(
  parameter int SIZE = SIZE_D,
  parameter int NREQ = NREQ_D,
  parameter int IDW = IDW_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] req_data,
  output logic [NREQ-1:0]      grant,
  output logic                 reg_load,
  output logic [SIZE-1:0]      reg_din,
  input  logic [SIZE-1:0]      reg_q,
  output logic                 out_valid,
  output logic [SIZE-1:0]      out_data,
  output logic [IDW-1:0]       out_id,
  input  logic                 out_ready
);
  state_e st_q, st_d;
  logic [IDW-1:0] p_q, p_d, id_q, id_d, win_idx;
  logic [NREQ-1:0] win_oh;
  logic accept;
  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (.req(req), .p(p_q), .win(win_oh), .idx(win_idx));
  assign accept = ~rst & |req & (st_q == ST_EMPTY | out_ready);
  assign grant = accept ? win_oh : '0;
  assign reg_load = accept;
  always_comb begin
    reg_din = '0;
    for (int i = 0; i < NREQ; i++) reg_din = reg_din | (req_data[i*SIZE +: SIZE] & {SIZE{grant[i]}});
  end
  always_comb begin
    st_d = accept ? ST_FULL : (st_q == ST_FULL && out_ready) ? ST_EMPTY : st_q;
    p_d = !accept ? p_q : win_idx == IDW'(NREQ - 1) ? '0 : win_idx + 1'b1;
    id_d = accept ? win_idx : id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_EMPTY;
      p_q <= '0;
      id_q <= '0;
    end else begin
      st_q <= st_d;
      p_q <= p_d;
      id_q <= id_d;
    end
  end
  assign out_valid = st_q == ST_FULL;
  assign out_data = reg_q;
  assign out_id = id_q;
endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter: scoreboard bench for reg_load_arbiter with a behavioural shared register
module tb_reg_load_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [127:0] req_data;
  logic [3:0] grant;
  logic reg_load;
  logic [31:0] reg_din;
  logic [31:0] reg_q = '0;
  logic out_valid;
  logic [31:0] out_data;
  logic [1:0] out_id;
  logic out_ready;
  logic [31:0] dat [4];
  logic [3:0] gq [$];
  logic [33:0] oq [$];
  int checks = 0;
  int errors = 0;

  reg_load_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .reg_load(reg_load), .reg_din(reg_din), .reg_q(reg_q), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (reg_load) reg_q <= reg_din;

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    return oh[3] ? 2'd3 : oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic rdy, input logic [3:0] eg);
    req = r;
    out_ready = rdy;
    gq.push_back(eg);
    if (eg != 0) oq.push_back({oh2i(eg), dat[oh2i(eg)]});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [3:0] eg;
    logic [33:0] eo;
    if (gq.size() != 0) begin
      eg = gq.pop_front();
      chk("grant", {28'd0, grant}, {28'd0, eg});
      chk("reg_load", {31'd0, reg_load}, {31'd0, eg != 0});
      chk("reg_din", reg_din, eg != 0 ? dat[oh2i(eg)] : 32'd0);
    end
    if (out_valid && out_ready) begin
      if (oq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got id %0d data %h expected none at %0t", out_id, out_data, $time);
      end else begin
        eo = oq.pop_front();
        chk("out_id", {30'd0, out_id}, {30'd0, eo[33:32]});
        chk("out_data", out_data, eo[31:0]);
      end
    end
  end

  initial begin
    dat[0] = 32'h11110000;
    dat[1] = 32'h22221111;
    dat[2] = 32'hDEADBEEF;
    dat[3] = 32'h33334444;
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    rst = 1'b1;
    req = 4'b0000;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(4'b1111, 1'b0, 4'b0000);
    cyc(4'b1111, 1'b0, 4'b0000);
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_id", {30'd0, out_id}, 32'd0);
    cyc(4'b1111, 1'b1, 4'b0001);
    cyc(4'b1111, 1'b1, 4'b0010);
    cyc(4'b1111, 1'b1, 4'b0100);
    cyc(4'b1111, 1'b1, 4'b1000);
    cyc(4'b1111, 1'b1, 4'b0001);
    cyc(4'b0000, 1'b1, 4'b0000);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    cyc(4'b0100, 1'b1, 4'b0100);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_id", {30'd0, out_id}, 32'd2);
    chk("single_data", out_data, 32'hDEADBEEF);
    cyc(4'b0000, 1'b1, 4'b0000);
    cyc(4'b1000, 1'b0, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0011, 1'b0, 4'b0000);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", out_data, 32'h33334444);
    end
    cyc(4'b0011, 1'b1, 4'b0001);
    chk("bp_release_id", {30'd0, out_id}, 32'd0);
    cyc(4'b1000, 1'b1, 4'b1000);
    cyc(4'b1001, 1'b1, 4'b0001);
    cyc(4'b1001, 1'b1, 4'b1000);
    cyc(4'b0000, 1'b1, 4'b0000);
    cyc(4'b0010, 1'b0, 4'b0010);
    chk("pre_rst_id", {30'd0, out_id}, 32'd1);
    rst = 1'b1;
    cyc(4'b0011, 1'b0, 4'b0000);
    rst = 1'b0;
    oq.delete();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_id", {30'd0, out_id}, 32'd0);
    cyc(4'b0110, 1'b1, 4'b0010);
    cyc(4'b0000, 1'b1, 4'b0000);
    @(negedge clk);
    chk("gq_empty", gq.size(), 32'd0);
    chk("oq_empty", oq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
